// File: rtl/fredkin_pkg.sv
// fredkin_pkg: shared constants, lane/key types and pair-index helpers for the
// Fredkin (keyed cswap butterfly) descrambler.
// Optional feature macro: FREDKIN_POPCHK_EN (adds the popcount helper).
package fredkin_pkg;

  localparam int unsigned LANES  = 8;
  localparam int unsigned LANE_W = 4;
  localparam int unsigned S      = 3;
  localparam int unsigned DW     = LANES * LANE_W;
  localparam int unsigned HALF   = LANES / 2;
  localparam int unsigned KW     = S * HALF;
  localparam int unsigned PW     = $clog2(DW + 1);

  typedef logic [LANES-1:0][LANE_W-1:0] lanes_t;
  typedef logic [KW-1:0]                key_t;

  // Low lane of pair j in stage s: insert a 0 at bit position s of j.
  function automatic int unsigned pair_lo(input int unsigned s, input int unsigned j);
    int unsigned d;
    d = 32'd1 << s;
    return ((j / d) * (2 * d)) + (j % d);
  endfunction

  // Key bit that controls pair j of stage s.
  function automatic int unsigned key_bit(input int unsigned s, input int unsigned j);
    return (s * HALF) + j;
  endfunction

`ifdef FREDKIN_POPCHK_EN
  function automatic logic [PW-1:0] popcount(input logic [DW-1:0] w);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < DW; i++) c = c + PW'(w[i]);
    return c;
  endfunction
`endif

endpackage

// File: rtl/fredkin_stage.sv
// fredkin_stage: one butterfly stage (HALF cswap gates at distance 2^STAGE)
// feeding its pipeline slot register and valid bit.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   key_bits  [HALF]     per-pair swap enables for this stage
//   load_en              slot may load this cycle (empty or draining)
//   up_valid, up_data    upstream beat
//   valid, data          slot contents
//   up_pop, pop          carried popcount (FREDKIN_POPCHK_EN only)
module fredkin_stage
  import fredkin_pkg::*;
#(
  parameter int unsigned STAGE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [HALF-1:0] key_bits,
  input  logic            load_en,
  input  logic            up_valid,
  input  logic [DW-1:0]   up_data,
`ifdef FREDKIN_POPCHK_EN
  input  logic [PW-1:0]   up_pop,
  output logic [PW-1:0]   pop,
`endif
  output logic            valid,
  output logic [DW-1:0]   data
);

  localparam int unsigned D = 32'd1 << STAGE;

  lanes_t up_lanes;
  lanes_t swp_c;

  assign up_lanes = up_data;

  // Controlled swap of each pair (lo, lo+D).
  for (genvar j = 0; j < HALF; j++) begin : g_pair
    localparam int unsigned LO = pair_lo(STAGE, j);
    localparam int unsigned HI = LO + D;
    assign swp_c[LO] = key_bits[j] ? up_lanes[HI] : up_lanes[LO];
    assign swp_c[HI] = key_bits[j] ? up_lanes[LO] : up_lanes[HI];
  end

  // Slot register; data only updates when a real beat arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load_en) begin
      valid <= up_valid;
      if (up_valid) data <= swp_c;
    end
  end

`ifdef FREDKIN_POPCHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    pop <= '0;
    else if (load_en && up_valid)  pop <= up_pop;
  end
`endif

endmodule

// File: rtl/fredkin_descrambler.sv
// fredkin_descrambler: undoes a keyed cswap butterfly by applying stages
// S-1..0 in an S-deep valid/ready pipeline.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   key_in, key_load      key capture, honoured while key_ready
//   key_ready             pipeline empty and no beat accepted this cycle
//   in_data/valid/ready   scrambled input stream
//   out_data/valid/ready  descrambled output stream (slot S-1 register)
//   pop_err               popcount check pulse (FREDKIN_POPCHK_EN only)
// Optional feature macro: FREDKIN_POPCHK_EN.
module fredkin_descrambler
  import fredkin_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [KW-1:0] key_in,
  input  logic          key_load,
  output logic          key_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
`ifdef FREDKIN_POPCHK_EN
  output logic          pop_err,
`endif
  input  logic          out_ready
);

  key_t          key_q;
  logic [S-1:0]  vld;
  logic [DW-1:0] dat [S];
  logic          empty_c;
  logic          ld0_c;
  logic          acc_c;
`ifdef FREDKIN_POPCHK_EN
  logic [PW-1:0] pop [S];
`endif

  // A key load takes priority over an input beat when the pipe is empty.
  assign empty_c   = ~|vld;
  assign ld0_c     = out_ready | ~(&vld);
  assign in_ready  = ld0_c & ~(key_load & empty_c);
  assign acc_c     = in_valid & in_ready;
  assign key_ready = empty_c & ~acc_c;

  // Key only changes while nothing is in flight, so one register suffices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      key_q <= '0;
    else if (key_load && key_ready)  key_q <= key_in;
  end

  for (genvar p = 0; p < S; p++) begin : g_slot
    localparam int unsigned STG = S - 1 - p;
    logic          ld_c;
    logic          up_v_c;
    logic [DW-1:0] up_d_c;
`ifdef FREDKIN_POPCHK_EN
    logic [PW-1:0] up_p_c;
`endif

    // Slot p can load if any slot from p to the output is empty, or the output drains.
    assign ld_c = out_ready | ~(&vld[S-1:p]);

    if (p == 0) begin : g_first
      assign up_v_c = acc_c;
      assign up_d_c = in_data;
`ifdef FREDKIN_POPCHK_EN
      assign up_p_c = popcount(in_data);
`endif
    end else begin : g_next
      assign up_v_c = vld[p-1];
      assign up_d_c = dat[p-1];
`ifdef FREDKIN_POPCHK_EN
      assign up_p_c = pop[p-1];
`endif
    end

    fredkin_stage #(.STAGE(STG)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_bits (key_q[key_bit(STG, 0) +: HALF]),
      .load_en  (ld_c),
      .up_valid (up_v_c),
      .up_data  (up_d_c),
`ifdef FREDKIN_POPCHK_EN
      .up_pop   (up_p_c),
      .pop      (pop[p]),
`endif
      .valid    (vld[p]),
      .data     (dat[p])
    );
  end

  assign out_valid = vld[S-1];
  assign out_data  = dat[S-1];

`ifdef FREDKIN_POPCHK_EN
  // Swaps conserve ones; flag any beat whose count changed in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pop_err <= 1'b0;
    else        pop_err <= out_valid & out_ready & (popcount(out_data) != pop[S-1]);
  end
`endif

endmodule

// File: tb/tb_fredkin_descrambler.sv
`timescale 1ns/1ps
module tb_fredkin_descrambler;

  localparam int LANES = 8;
  localparam int LW    = 4;
  localparam int NS    = 3;
  localparam int DW    = LANES * LW;
  localparam int KW    = NS * LANES / 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [KW-1:0] key_in = '0;
  logic          key_load = 1'b0;
  logic          key_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
`ifdef FREDKIN_POPCHK_EN
  logic          pop_err;
`endif

  always #5 clk = ~clk;

  fredkin_descrambler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_load  (key_load),
    .key_ready (key_ready),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
`ifdef FREDKIN_POPCHK_EN
    .pop_err   (pop_err),
`endif
    .out_ready (out_ready)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    bit            chk_lat;
    bit            skip;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic [KW-1:0] mkey = '0;
  bit            lat_mode = 1'b0;
  bit            skip_next = 1'b0;
  bit            ign_pop = 1'b0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Reference model: one scrambler stage, pairs enumerated in ascending low-lane order.
  function automatic logic [DW-1:0] stage_swap(input logic [DW-1:0] w, input int s,
                                               input logic [KW-1:0] key);
    logic [LW-1:0] ln [LANES];
    logic [LW-1:0] t;
    int d;
    int j;
    d = 1 << s;
    j = 0;
    for (int i = 0; i < LANES; i++) ln[i] = w[i*LW +: LW];
    for (int i = 0; i < LANES; i++) begin
      if (((i / d) % 2) == 0) begin
        if (key[s*(LANES/2) + j]) begin
          t = ln[i]; ln[i] = ln[i+d]; ln[i+d] = t;
        end
        j++;
      end
    end
    for (int i = 0; i < LANES; i++) stage_swap[i*LW +: LW] = ln[i];
  endfunction

  function automatic logic [DW-1:0] scramble(input logic [DW-1:0] w, input logic [KW-1:0] k);
    logic [DW-1:0] r;
    r = w;
    for (int s = 0; s < NS; s++) r = stage_swap(r, s, k);
    return r;
  endfunction

  function automatic logic [DW-1:0] descramble(input logic [DW-1:0] w, input logic [KW-1:0] k);
    logic [DW-1:0] r;
    r = w;
    for (int s = NS - 1; s >= 0; s--) r = stage_swap(r, s, k);
    return r;
  endfunction

  task automatic push(input logic [DW-1:0] e);
    sb.push_back('{data: e, cyc: cyc, chk_lat: lat_mode, skip: skip_next});
    skip_next = 1'b0;
  endtask

  // Monitor: pops expected beats on every output handshake, checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_hold", 32'(out_valid), 32'd1);
        check("stall_data_hold", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          fail("unexpected_beat");
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (!e.skip) check("out_data", out_data, e.data);
          if (e.chk_lat) check("latency", 32'(cyc - e.cyc), 32'd3);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
`ifdef FREDKIN_POPCHK_EN
      if (!ign_pop) check("pop_err_idle", 32'(pop_err), 32'd0);
`endif
    end
  end

  // Present a beat and hold it until accepted; returns at posedge+1 with in_valid low.
  task automatic send(input logic [DW-1:0] w, input logic [DW-1:0] e);
    bit done;
    done = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        push(e);
        done = 1'b1;
      end
      @(posedge clk) #1;
    end
    if (!done) fail("send_timeout");
    in_valid = 1'b0;
  endtask

  task automatic wait_key_ready();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (key_ready) done = 1'b1;
    end
    if (!done) fail("key_ready_timeout");
    @(posedge clk) #1;
  endtask

  task automatic load_key(input logic [KW-1:0] k);
    wait_key_ready();
    key_in   = k;
    key_load = 1'b1;
    @(negedge clk);
    check("key_ready_load", 32'(key_ready), 32'd1);
    @(posedge clk) #1;
    key_load = 1'b0;
    mkey     = k;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) fail("drain_timeout");
    @(posedge clk) #1;
  endtask

  // Random valid/ready stream under the current key.
  task automatic stream(input int n);
    int            sent;
    bit            pend;
    logic [DW-1:0] w;
    sent = 0;
    pend = 1'b0;
    w    = '0;
    for (int t = 0; t < 20000 && sent < n; t++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pend && $urandom_range(0, 3) != 0) begin
        w    = $urandom;
        pend = 1'b1;
      end
      in_valid = pend;
      in_data  = w;
      @(negedge clk);
      if (in_valid && in_ready) begin
        push(descramble(w, mkey));
        pend = 1'b0;
        sent++;
      end
      @(posedge clk) #1;
    end
    if (sent < n) fail("stream_timeout");
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a [4];
    logic [DW-1:0] ea [4];
    logic [DW-1:0] w;
    logic [KW-1:0] k;

    // Reset values
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_key_ready", 32'(key_ready), 32'd1);
`ifdef FREDKIN_POPCHK_EN
    check("rst_pop_err", 32'(pop_err), 32'd0);
`endif
    @(posedge clk) #1;
    rst_n = 1'b1;
    @(posedge clk) #1;

    // Identity key, latency check
    lat_mode = 1'b1;
    send(32'h76543210, 32'h76543210);
    wait_idle();

    // Single-stage keys
    load_key(12'h00F);
    send(32'h76543210, 32'h67452301);
    wait_idle();
    load_key(12'hF00);
    send(32'h76543210, 32'h32107654);
    wait_idle();

    // Round trip through the scrambler model
    for (int i = 0; i < 500; i++) begin
      k = KW'($urandom);
      w = $urandom;
      load_key(k);
      send(scramble(w, k), w);
    end
    wait_idle();

    // Random backpressure stream
    lat_mode = 1'b0;
    load_key(KW'($urandom));
    stream(300);
    wait_idle();

    // Stall: 3 beats fill the pipe, 4th waits, data holds
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = $urandom;
      ea[i] = descramble(a[i], mkey);
    end
    for (int i = 0; i < 3; i++) send(a[i], ea[i]);
    in_data  = a[3];
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_out_valid", 32'(out_valid), 32'd1);
      check("full_out_data", out_data, ea[0]);
      @(posedge clk) #1;
    end
    out_ready = 1'b1;
    send(a[3], ea[3]);
    wait_idle();

    // key_load while busy is ignored
    k = mkey;
    send(32'h13579bdf, descramble(32'h13579bdf, mkey));
    key_in   = ~k;
    key_load = 1'b1;
    @(negedge clk);
    check("busy_key_ready", 32'(key_ready), 32'd0);
    @(posedge clk) #1;
    key_load = 1'b0;
    wait_idle();
    send(32'h76543210, descramble(32'h76543210, mkey));
    wait_idle();

    // key_load + in_valid on empty pipe: key wins
    wait_key_ready();
    k        = KW'($urandom) | 12'h001;
    w        = $urandom;
    key_in   = k;
    key_load = 1'b1;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    check("keywin_in_ready", 32'(in_ready), 32'd0);
    check("keywin_key_ready", 32'(key_ready), 32'd1);
    @(posedge clk) #1;
    key_load = 1'b0;
    mkey     = k;
    send(w, descramble(w, k));
    wait_idle();

    // Async reset with beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'($urandom), 32'h0);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", out_data, 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_key_ready", 32'(key_ready), 32'd1);
    sb.delete();
    mkey = '0;
    @(posedge clk) #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("post_rst_no_beat", 32'(out_valid), 32'd0);
    @(posedge clk) #1;
    send(32'h76543210, 32'h76543210);
    wait_idle();

`ifdef FREDKIN_POPCHK_EN
    // Corrupt a bit in slot 1 and expect one pop_err pulse
    begin
      logic [DW-1:0] v;
      ign_pop   = 1'b1;
      skip_next = 1'b1;
      send(32'h0000ffff, 32'h0);
      @(posedge clk) #1;
      v = dut.g_slot[1].u_stage.data;
      force dut.g_slot[1].u_stage.data = v ^ 32'h1;
      @(posedge clk) #1;
      release dut.g_slot[1].u_stage.data;
      @(negedge clk);
      check("popchk_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      check("pop_err_pulse", 32'(pop_err), 32'd1);
      @(negedge clk);
      check("pop_err_clear", 32'(pop_err), 32'd0);
      ign_pop = 1'b0;
      @(posedge clk) #1;
    end
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
